// File: rtl/bf_bus_bridge_pkg.sv
// Shared types for the BF interpreter bus bridge: core bus operations,
// bridge lifecycle states and the read-data source select.
package bf_bus_bridge_pkg;

   typedef enum logic [2:0] {
      BusNone      = 3'd0,
      BusReadProg  = 3'd1,
      BusReadData  = 3'd2,
      BusWriteData = 3'd3,
      BusReadIo    = 3'd4,
      BusWriteIo   = 3'd5
   } bus_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TERM,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } bridge_state_t;

   typedef enum logic [1:0] {
      RSEL_NONE,
      RSEL_PROG,
      RSEL_DATA,
      RSEL_IO
   } rd_sel_t;

   // States in which a program byte may be streamed in.
   function automatic logic load_open(input bridge_state_t s);
      return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/bf_out_reg.sv
// One-entry valid/ready output register. A load is taken whenever the slot is
// empty or draining this cycle; otherwise the requester is told to stall.
module bf_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             stall
);

   assign stall = load && out_valid && !out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load && !stall) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/bf_bus_bridge.sv
// Bus bridge below the BF core: loads the program, zeroes data memory, runs the
// core against pm/dm/byte-stream I/O with stalls, and reports completion.
module bf_bus_bridge
   import bf_bus_bridge_pkg::*;
#(
   parameter int PROG_ADDR_WIDTH = 15,
   parameter int DATA_ADDR_WIDTH = 15,
   parameter int ADDR_WIDTH      = 15,
   parameter int BUS_WIDTH       = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       load_valid,
   input  logic [BUS_WIDTH-1:0]       load_data,
   input  logic                       load_last,
   output logic                       load_ready,
   output logic                       load_err,
   input  logic [ADDR_WIDTH-1:0]      core_addr,
   input  logic [BUS_WIDTH-1:0]       core_val_out,
   input  bus_op_t                    core_bus_op,
   input  logic                       core_halted,
   output logic [BUS_WIDTH-1:0]       core_val_in,
   output logic                       core_enable,
   output logic                       core_reset,
   output logic [PROG_ADDR_WIDTH-1:0] pm_addr,
   output logic [BUS_WIDTH-1:0]       pm_wdata,
   output logic                       pm_we,
   output logic                       pm_re,
   input  logic [BUS_WIDTH-1:0]       pm_rdata,
   output logic [DATA_ADDR_WIDTH-1:0] dm_addr,
   output logic [BUS_WIDTH-1:0]       dm_wdata,
   output logic                       dm_we,
   output logic                       dm_re,
   input  logic [BUS_WIDTH-1:0]       dm_rdata,
   input  logic                       in_valid,
   input  logic [BUS_WIDTH-1:0]       in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [BUS_WIDTH-1:0]       out_data,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output bridge_state_t              state
);

   localparam logic [PROG_ADDR_WIDTH-1:0] PROG_LAST = '1;
   localparam logic [PROG_ADDR_WIDTH-1:0] PROG_ONE  = PROG_ADDR_WIDTH'(1);
   localparam logic [DATA_ADDR_WIDTH-1:0] DATA_LAST = '1;
   localparam logic [DATA_ADDR_WIDTH-1:0] DATA_ONE  = DATA_ADDR_WIDTH'(1);

   logic [PROG_ADDR_WIDTH-1:0] load_ptr;
   logic [PROG_ADDR_WIDTH-1:0] wr_ptr;
   logic [PROG_ADDR_WIDTH-1:0] next_ptr;
   logic [DATA_ADDR_WIDTH-1:0] clr_ptr;
   logic [BUS_WIDTH-1:0]       io_reg;
   rd_sel_t                    rsel;
   bus_op_t                    op;
   logic                       run;
   logic                       load_take;
   logic                       load_overflow;
   logic                       io_stall;
   logic                       out_stall;

   assign run        = (state == ST_RUN);
   assign load_ready = load_open(state);
   assign load_take  = load_valid && load_ready;
   assign busy       = !(state == ST_IDLE || state == ST_DONE);
   assign done       = (state == ST_DONE);

   // A reload from DONE restarts the program at address 0.
   assign wr_ptr        = (state == ST_DONE) ? '0 : load_ptr;
   assign next_ptr      = wr_ptr + PROG_ONE;
   assign load_overflow = !load_last && (next_ptr == PROG_LAST);

   // Core ops only matter while running; unknown encodings behave as None.
   always_comb begin
      op = BusNone;
      if (run) begin
         case (core_bus_op)
            BusReadProg, BusReadData, BusWriteData, BusReadIo, BusWriteIo: op = core_bus_op;
            default: op = BusNone;
         endcase
      end
   end

   assign in_ready    = (op == BusReadIo);
   assign io_stall    = (op == BusReadIo) && !in_valid;
   assign core_enable = run && !io_stall && !out_stall;

   bf_out_reg #(
      .WIDTH (BUS_WIDTH)
   ) u_out_reg (
      .clock     (clock),
      .reset     (reset),
      .load      (op == BusWriteIo),
      .load_data (core_val_out),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .stall     (out_stall)
   );

   always_comb begin
      case (rsel)
         RSEL_PROG: core_val_in = pm_rdata;
         RSEL_DATA: core_val_in = dm_rdata;
         RSEL_IO:   core_val_in = io_reg;
         default:   core_val_in = '0;
      endcase
   end

   always_comb begin
      pm_addr  = load_ptr;
      pm_wdata = '0;
      pm_we    = 1'b0;
      pm_re    = 1'b0;
      dm_addr  = clr_ptr;
      dm_wdata = '0;
      dm_we    = 1'b0;
      dm_re    = 1'b0;
      case (state)
         ST_IDLE, ST_LOAD, ST_DONE: begin
            pm_addr  = wr_ptr;
            pm_wdata = load_data;
            pm_we    = load_take;
         end
         ST_TERM:  pm_we = 1'b1;
         ST_CLEAR: dm_we = 1'b1;
         ST_RUN: begin
            pm_addr  = core_addr[PROG_ADDR_WIDTH-1:0];
            dm_addr  = core_addr[DATA_ADDR_WIDTH-1:0];
            pm_wdata = core_val_out;
            dm_wdata = core_val_out;
            pm_re    = core_enable && (op == BusReadProg);
            dm_re    = core_enable && (op == BusReadData);
            dm_we    = core_enable && (op == BusWriteData);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         core_reset <= 1'b1;
         load_err   <= 1'b0;
         load_ptr   <= '0;
         clr_ptr    <= '0;
         rsel       <= RSEL_NONE;
         io_reg     <= '0;
      end else begin
         // rsel tracks the most recent enabled read; memories hold rdata meanwhile.
         if (core_enable) begin
            case (op)
               BusReadProg: rsel <= RSEL_PROG;
               BusReadData: rsel <= RSEL_DATA;
               BusReadIo: begin
                  rsel   <= RSEL_IO;
                  io_reg <= in_data;
               end
               default: ;
            endcase
         end
         case (state)
            ST_IDLE, ST_LOAD, ST_DONE: begin
               if (load_take) begin
                  load_ptr <= next_ptr;
                  if (state == ST_DONE) begin
                     load_err   <= 1'b0;
                     core_reset <= 1'b1;
                  end
                  if (load_last) begin
                     state <= ST_TERM;
                  end else if (load_overflow) begin
                     load_err <= 1'b1;
                     state    <= ST_TERM;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_TERM: begin
               clr_ptr <= '0;
               state   <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (clr_ptr == DATA_LAST) begin
                  core_reset <= 1'b0;
                  state      <= ST_RUN;
               end else begin
                  clr_ptr <= clr_ptr + DATA_ONE;
               end
            end
            ST_RUN:   if (core_halted) state <= ST_DRAIN;
            ST_DRAIN: if (!out_valid) state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bf_bus_bridge.sv
// Bench for bf_bus_bridge: small behavioural BF core and memories around the
// bridge, directed lifecycle/stall scenarios and an output byte scoreboard.
module tb_bf_bus_bridge;
   import bf_bus_bridge_pkg::*;

   localparam int PW = 3;
   localparam int DW = 4;
   localparam int AW = 4;
   localparam int BW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic [BW-1:0] load_data = '0;
   logic          load_last = 1'b0;
   logic          load_ready;
   logic          load_err;
   logic [AW-1:0] core_addr;
   logic [BW-1:0] core_val_out;
   bus_op_t       core_bus_op;
   logic          core_halted;
   logic [BW-1:0] core_val_in;
   logic          core_enable;
   logic          core_reset;
   logic [PW-1:0] pm_addr;
   logic [BW-1:0] pm_wdata;
   logic          pm_we;
   logic          pm_re;
   logic [BW-1:0] pm_rdata = '0;
   logic [DW-1:0] dm_addr;
   logic [BW-1:0] dm_wdata;
   logic          dm_we;
   logic          dm_re;
   logic [BW-1:0] dm_rdata = '0;
   logic          in_valid = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [BW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;
   bridge_state_t state;

   int n_vec = 0;
   int n_err = 0;
   int clr_total = 0;
   int ready_bad = 0;
   int creset_bad = 0;
   logic [BW-1:0] exp_q[$];

   always #5 clock = ~clock;

   bf_bus_bridge #(
      .PROG_ADDR_WIDTH (PW),
      .DATA_ADDR_WIDTH (DW),
      .ADDR_WIDTH      (AW),
      .BUS_WIDTH       (BW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .load_err     (load_err),
      .core_addr    (core_addr),
      .core_val_out (core_val_out),
      .core_bus_op  (core_bus_op),
      .core_halted  (core_halted),
      .core_val_in  (core_val_in),
      .core_enable  (core_enable),
      .core_reset   (core_reset),
      .pm_addr      (pm_addr),
      .pm_wdata     (pm_wdata),
      .pm_we        (pm_we),
      .pm_re        (pm_re),
      .pm_rdata     (pm_rdata),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_we        (dm_we),
      .dm_re        (dm_re),
      .dm_rdata     (dm_rdata),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .state        (state)
   );

   // Synchronous-read memories that hold rdata while re is low.
   logic [BW-1:0] pm_mem [0:(1<<PW)-1];
   logic [BW-1:0] dm_mem [0:(1<<DW)-1];
   always @(posedge clock) begin
      if (pm_we) pm_mem[pm_addr] <= pm_wdata;
      if (pm_re) pm_rdata <= pm_mem[pm_addr];
      if (dm_we) dm_mem[dm_addr] <= dm_wdata;
      if (dm_re) dm_rdata <= dm_mem[dm_addr];
   end

   // Minimal BF core: handles + - . , > < and halts on 0x00.
   typedef enum logic [2:0] {C_FETCH, C_DECODE, C_RD, C_MOD, C_OUT, C_IN, C_STORE, C_HALT} core_st_t;
   core_st_t      cst;
   logic [AW-1:0] pc;
   logic [AW-1:0] dp;
   logic [BW-1:0] instr;

   always @(posedge clock) begin
      if (core_reset) begin
         cst <= C_FETCH; pc <= '0; dp <= '0; instr <= '0;
      end else if (core_enable) begin
         case (cst)
            C_FETCH: cst <= C_DECODE;
            C_DECODE: begin
               instr <= core_val_in;
               case (core_val_in)
                  8'h00: cst <= C_HALT;
                  8'h2B, 8'h2D, 8'h2E: cst <= C_RD;
                  8'h2C: cst <= C_IN;
                  8'h3E: begin dp <= dp + 4'd1; pc <= pc + 4'd1; cst <= C_FETCH; end
                  8'h3C: begin dp <= dp - 4'd1; pc <= pc + 4'd1; cst <= C_FETCH; end
                  default: begin pc <= pc + 4'd1; cst <= C_FETCH; end
               endcase
            end
            C_RD:    cst <= (instr == 8'h2E) ? C_OUT : C_MOD;
            C_IN:    cst <= C_STORE;
            C_MOD, C_OUT, C_STORE: begin pc <= pc + 4'd1; cst <= C_FETCH; end
            default: ;
         endcase
      end
   end

   always_comb begin
      core_bus_op  = BusNone;
      core_addr    = pc;
      core_val_out = '0;
      case (cst)
         C_FETCH: core_bus_op = BusReadProg;
         C_RD:    begin core_bus_op = BusReadData; core_addr = dp; end
         C_MOD: begin
            core_bus_op  = BusWriteData;
            core_addr    = dp;
            core_val_out = (instr == 8'h2B) ? core_val_in + 8'd1 : core_val_in - 8'd1;
         end
         C_OUT:   begin core_bus_op = BusWriteIo; core_val_out = core_val_in; end
         C_IN:    core_bus_op = BusReadIo;
         C_STORE: begin core_bus_op = BusWriteData; core_addr = dp; core_val_out = core_val_in; end
         default: ;
      endcase
   end
   assign core_halted = (cst == C_HALT);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output scoreboard plus per-state invariants on load_ready and core_reset.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL out_extra: observed %0h expected no byte", out_data);
         end else begin
            check("out_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
         end
      end
      if (!reset && state == ST_CLEAR && dm_we && dm_wdata == 8'h00) clr_total++;
      if (!reset && !load_open(state) && load_ready) ready_bad++;
      if (!reset && core_reset !== (state inside {ST_IDLE, ST_LOAD, ST_TERM, ST_CLEAR})) creset_bad++;
   end

   task automatic send_byte(input logic [7:0] b, input logic last, input int budget, output logic took);
      took = 1'b0;
      load_valid = 1'b1; load_data = b; load_last = last;
      for (int k = 0; k < budget && !took; k++) begin
         @(negedge clock);
         took = load_ready;
         @(posedge clock);
         #1;
      end
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic load_prog(input string s, output int acc);
      logic took;
      logic [7:0] b;
      acc = 0;
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         send_byte(b, i == s.len() - 1, 20, took);
         if (took) acc++;
      end
   endtask

   task automatic wait_state(input bridge_state_t target, input int budget, input string tag);
      int k;
      k = 0;
      while (state != target && k < budget) begin
         @(posedge clock); #1; k++;
      end
      check(tag, state, target);
   endtask

   task automatic wait_second_out(input int budget, input string tag);
      int k;
      k = 0;
      while (!(cst == C_OUT && pc == 4'd3) && k < budget) begin
         @(posedge clock); #1; k++;
      end
      check(tag, {31'h0, (cst == C_OUT && pc == 4'd3)}, 32'h1);
   endtask

   initial begin
      int acc;
      int clr_base;
      int bad;
      logic took;
      logic [7:0] b;
      string ovf;

      // Reset values.
      @(negedge clock);
      check("rst_state", state, ST_IDLE);
      check("rst_core_reset", core_reset, 1'b1);
      check("rst_core_enable", core_enable, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_done_busy", {done, busy}, 2'b00);
      check("rst_load_ready", load_ready, 1'b1);
      check("rst_mem_en", {pm_we, pm_re, dm_we, dm_re}, 4'b0000);
      check("rst_out_data", out_data, 8'h00);
      check("rst_val_in", core_val_in, 8'h00);
      @(posedge clock); #1;
      reset = 1'b0;

      // "+." : load, terminator, 16-address clear, one output byte, done.
      out_ready = 1'b1;
      clr_base = clr_total;
      exp_q.push_back(8'h01);
      load_prog("+.", acc);
      check("a_accepted", acc, 2);
      check("a_term_ready", load_ready, 1'b0);
      wait_state(ST_RUN, 40, "a_reach_run");
      check("a_clear_writes", clr_total - clr_base, 16);
      check("a_run_core_reset", core_reset, 1'b0);
      check("a_pm0", pm_mem[0], 8'h2B);
      check("a_pm1", pm_mem[1], 8'h2E);
      check("a_pm2", pm_mem[2], 8'h00);
      wait_state(ST_DONE, 200, "a_reach_done");
      check("a_done_busy", {done, busy}, 2'b10);
      check("a_done_ctrl", {core_enable, core_reset, load_ready}, 3'b001);
      check("a_drained", exp_q.size(), 0);

      // "+.+." with sink blocked: first byte held, second WriteIo stalls, order kept.
      out_ready = 1'b0;
      b = "+";
      send_byte(b, 1'b0, 20, took);
      check("b_reload_core_reset", core_reset, 1'b1);
      check("b_reload_state", state, ST_LOAD);
      check("b_reload_done", done, 1'b0);
      b = "."; send_byte(b, 1'b0, 20, took);
      b = "+"; send_byte(b, 1'b0, 20, took);
      b = "."; send_byte(b, 1'b1, 20, took);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      wait_second_out(300, "b_second_out_seen");
      check("b_held_valid", out_valid, 1'b1);
      check("b_held_data", out_data, 8'h01);
      check("b_stall_enable", core_enable, 1'b0);
      repeat (5) begin @(posedge clock); #1; end
      check("b_stall_persist", {core_enable, out_data}, {1'b0, 8'h01});
      out_ready = 1'b1;
      wait_state(ST_DONE, 200, "b_reach_done");
      check("b_drained", exp_q.size(), 0);

      // ",." with no input: in_ready high and core stalled for 10 cycles, then 0x41 echoes.
      load_prog(",.", acc);
      begin
         int k;
         k = 0;
         while (core_bus_op != BusReadIo && k < 100) begin @(posedge clock); #1; k++; end
      end
      check("c_readio_seen", core_bus_op, BusReadIo);
      bad = 0;
      repeat (10) begin
         @(negedge clock);
         if (!(in_ready === 1'b1 && core_enable === 1'b0)) bad++;
      end
      check("c_stall_10", bad, 0);
      @(posedge clock); #1;
      in_valid = 1'b1; in_data = 8'h41;
      exp_q.push_back(8'h41);
      @(posedge clock); #1;
      in_valid = 1'b0;
      wait_state(ST_DONE, 200, "c_reach_done");
      check("c_dm0", dm_mem[0], 8'h41);
      check("c_drained", exp_q.size(), 0);

      // Ten bytes, no last, into an 8-entry program memory.
      ovf = "+>+>+>+>+>";
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         b = ovf[i];
         send_byte(b, 1'b0, 3, took);
         if (took) acc++;
      end
      check("d_accepted", acc, 7);
      wait_state(ST_DONE, 300, "d_reach_done");
      check("d_load_err", load_err, 1'b1);
      for (int i = 0; i < 7; i++) begin
         b = ovf[i];
         check("d_pm_byte", pm_mem[i], b);
      end
      check("d_pm_term", pm_mem[7], 8'h00);
      check("d_dm3", dm_mem[3], 8'h01);

      // Reset during a WriteIo stall, then a reload re-zeroes data memory.
      out_ready = 1'b0;
      b = "+";
      send_byte(b, 1'b0, 20, took);
      check("e_err_cleared", load_err, 1'b0);
      b = "."; send_byte(b, 1'b0, 20, took);
      b = "+"; send_byte(b, 1'b0, 20, took);
      b = "."; send_byte(b, 1'b1, 20, took);
      wait_second_out(300, "e_second_out_seen");
      check("e_stalled", {core_enable, out_valid}, 2'b01);
      reset = 1'b1;
      @(negedge clock);
      check("e_rst_out_valid", out_valid, 1'b0);
      check("e_rst_core_reset", core_reset, 1'b1);
      check("e_rst_state", state, ST_IDLE);
      @(posedge clock); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(8'h01);
      load_prog("+.", acc);
      wait_state(ST_DONE, 300, "e_reach_done");
      check("e_dm0", dm_mem[0], 8'h01);
      check("e_drained", exp_q.size(), 0);

      // "++." loaded from DONE.
      exp_q.push_back(8'h02);
      b = "+";
      send_byte(b, 1'b0, 20, took);
      check("f_core_reset", core_reset, 1'b1);
      b = "+"; send_byte(b, 1'b0, 20, took);
      b = "."; send_byte(b, 1'b1, 20, took);
      wait_state(ST_DONE, 300, "f_reach_done");
      check("f_done", done, 1'b1);
      check("f_drained", exp_q.size(), 0);

      check("inv_load_ready", ready_bad, 0);
      check("inv_core_reset", creset_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
